seq_detector_n: RTL and testbench

Runtime-configurable serial bit-pattern detector. It generalises the fixed 4-bit "1011" detector to any pattern of 1..PAT_W bits. The pattern, its length and overlapping/non-overlapping mode are loadable at run time, and the block keeps a saturating match counter. It sits on a serial data stream and raises a one-cycle `op` pulse per detected occurrence for downstream framing logic.

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/seq_det_cmp.sv | 21 ++
 rtl/seq_detector_n.sv | 104 ++++++++++
 tb/tb_seq_detector_n.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the runtime-configurable serial pattern detector.
// Config fields are sized for the largest supported pattern so the struct stays parameter-free.
package seq_det_pkg;

  localparam int unsigned CFG_PAT_W = 32;
  localparam int unsigned CFG_LW    = 6;

  localparam logic [7:0]  RST_PAT = 8'b0000_1011;
  localparam int unsigned RST_LEN = 4;
  localparam bit          RST_OVL = 1'b1;

  function automatic int unsigned lw_f(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  typedef struct packed {
    logic [CFG_PAT_W-1:0] pat;
    logic [CFG_LW-1:0]    len;
    logic                 ovl;
  } seq_cfg_t;

endpackage

// File: rtl/seq_det_cmp.sv
// Masked comparator: hit when the newest len_q history bits equal the low len_q pattern bits.
module seq_det_cmp
  import seq_det_pkg::*;
(
  input  logic [CFG_PAT_W-1:0] hist_next,
  input  logic [CFG_PAT_W-1:0] pat_q,
  input  logic [CFG_LW-1:0]    len_q,
  output logic                 hit
);

  logic [CFG_PAT_W-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < CFG_PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
    hit = ~|((hist_next ^ pat_q) & mask);
  end

endmodule

// File: rtl/seq_detector_n.sv
// Serial bit-pattern detector with loadable pattern/length/overlap mode, registered match
// pulse and saturating match counter.
module seq_detector_n #(
  parameter int unsigned      PAT_W   = 8,
  parameter int unsigned      CNT_W   = 16,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(seq_det_pkg::RST_PAT),
  parameter int unsigned      RST_LEN = seq_det_pkg::RST_LEN,
  parameter bit               RST_OVL = seq_det_pkg::RST_OVL,
  localparam int unsigned     LW      = seq_det_pkg::lw_f(PAT_W)
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pat,
  input  logic [LW-1:0]    pat_len,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             op,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err,
  output logic [LW-1:0]    fill
);

  import seq_det_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_cfg_t             cfg_q, cfg_d;
  logic [PAT_W-1:0]     hist_q, hist_d, hist_next;
  logic [CFG_LW-1:0]    fill_q, fill_d, fill_inc;
  logic                 op_d, err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_base;
  logic [CFG_PAT_W-1:0] hist_ext;
  logic                 hit, match;

  assign hist_next = {hist_q[PAT_W-2:0], x};
  assign hist_ext  = CFG_PAT_W'(hist_next);

  seq_det_cmp u_cmp (
    .hist_next (hist_ext),
    .pat_q     (cfg_q.pat),
    .len_q     (cfg_q.len),
    .hit       (hit)
  );

  // fill never exceeds len because len only changes on a load, which also clears fill
  assign fill_inc = (fill_q >= cfg_q.len) ? cfg_q.len : fill_q + CFG_LW'(1);
  assign match    = x_valid && !load && !err_q && (fill_inc == cfg_q.len) && hit;

  always_comb begin
    cfg_d  = cfg_q;
    hist_d = hist_q;
    fill_d = fill_q;
    err_d  = err_q;
    op_d   = 1'b0;

    if (load) begin
      cfg_d.pat = CFG_PAT_W'(pat);
      cfg_d.len = CFG_LW'(pat_len);
      cfg_d.ovl = overlap;
      hist_d    = '0;
      fill_d    = '0;
      err_d     = (pat_len == '0) || (CFG_LW'(pat_len) > CFG_LW'(PAT_W));
    end else if (x_valid) begin
      hist_d = hist_next;
      fill_d = fill_inc;
      if (match) begin
        op_d = 1'b1;
        if (!cfg_q.ovl) fill_d = '0;
      end
    end

    // A clear coinciding with a match still counts that match
    cnt_base = cnt_clr ? '0 : cnt_q;
    cnt_d    = (match && cnt_base != CNT_MAX) ? cnt_base + CNT_W'(1) : cnt_base;
  end

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      cfg_q.pat <= CFG_PAT_W'(RST_PAT);
      cfg_q.len <= CFG_LW'(RST_LEN);
      cfg_q.ovl <= RST_OVL;
      hist_q    <= '0;
      fill_q    <= '0;
      err_q     <= 1'b0;
      op        <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cfg_q     <= cfg_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      err_q     <= err_d;
      op        <= op_d;
      cnt_q     <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
  assign cfg_err   = err_q;
  assign fill      = fill_q[LW-1:0];

endmodule

// File: tb/tb_seq_detector_n.sv
// Bench for seq_detector_n: directed scenarios plus random traffic against a bit-queue model.
module tb_seq_detector_n;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        x = 1'b0, x_valid = 1'b0, load = 1'b0, overlap = 1'b0, cnt_clr = 1'b0;
  logic [7:0]  pat = '0;
  logic [3:0]  pat_len = '0;
  logic        op, cfg_err, op2, err2;
  logic [15:0] match_cnt;
  logic [1:0]  cnt2;
  logic [3:0]  fill, fill2;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          q[$];
  int unsigned m_pat, m_len, m_cnt, m_cnt2;
  bit          m_ovl, m_err, exp_op;

  seq_detector_n #(.PAT_W(8), .CNT_W(16)) dut (
    .clk(clk), .areset_n(areset_n), .x(x), .x_valid(x_valid), .load(load), .pat(pat),
    .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr), .op(op), .match_cnt(match_cnt),
    .cfg_err(cfg_err), .fill(fill)
  );

  seq_detector_n #(.PAT_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .areset_n(areset_n), .x(x), .x_valid(x_valid), .load(load), .pat(pat),
    .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr), .op(op2), .match_cnt(cnt2),
    .cfg_err(err2), .fill(fill2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit();
    int unsigned v = 0;
    if (m_err || q.size() != m_len) return 1'b0;
    foreach (q[i]) v = (v << 1) | 32'(q[i]);
    return v == (m_pat & ((32'd1 << m_len) - 1));
  endfunction

  task automatic model_update();
    exp_op = 1'b0;
    if (!areset_n) begin
      q.delete();
      m_pat = 32'h0B; m_len = 4; m_ovl = 1'b1; m_err = 1'b0; m_cnt = 0; m_cnt2 = 0;
      return;
    end
    if (load) begin
      m_pat = 32'(pat); m_len = 32'(pat_len); m_ovl = overlap;
      m_err = (pat_len == 0) || (pat_len > 8);
      q.delete();
    end else if (x_valid) begin
      q.push_back(x);
      while (q.size() > m_len) void'(q.pop_front());
      if (model_hit()) begin
        exp_op = 1'b1;
        if (!m_ovl) q.delete();
      end
    end
    if (cnt_clr) begin m_cnt = 0; m_cnt2 = 0; end
    if (exp_op) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic cyc();
    int unsigned exp_fill;
    model_update();
    @(posedge clk);
    #1;
    exp_fill = (q.size() < m_len) ? q.size() : m_len;
    chk("op", 32'(op), 32'(exp_op));
    chk("match_cnt", 32'(match_cnt), m_cnt);
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    chk("fill", 32'(fill), exp_fill);
    chk("op2", 32'(op2), 32'(exp_op));
    chk("cnt2", 32'(cnt2), m_cnt2);
    chk("cfg_err2", 32'(err2), 32'(m_err));
    chk("fill2", 32'(fill2), exp_fill);
    areset_n = 1'b1; load = 1'b0; cnt_clr = 1'b0; x_valid = 1'b0;
  endtask

  task automatic bit_in(input logic b);
    x = b; x_valid = 1'b1; cyc();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o,
                         input logic clr);
    pat = p; pat_len = l; overlap = o; load = 1'b1; cnt_clr = clr; x = 1'b1; x_valid = 1'b1;
    cyc();
  endtask

  task automatic do_reset();
    areset_n = 1'b0; load = 1'b1; cnt_clr = 1'b1; x_valid = 1'b1; cyc();
  endtask

  task automatic stream(input logic [31:0] bits, input int n);
    logic [31:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
  endtask

  initial begin
    int r;
    // Reset defaults: 1011, overlapping
    do_reset();
    do_reset();
    chk("reset_cnt", 32'(match_cnt), 0);
    chk("reset_op", 32'(op), 0);
    stream(32'b1011011, 7);
    chk("default_cnt", 32'(match_cnt), 2);

    // 1010, non-overlap then overlap
    do_load(8'b0000_1010, 4'd4, 1'b0, 1'b1);
    stream(32'b101010, 6);
    chk("nonovl_cnt", 32'(match_cnt), 1);
    do_load(8'b0000_1010, 4'd4, 1'b1, 1'b1);
    stream(32'b101010, 6);
    chk("ovl_cnt", 32'(match_cnt), 2);

    // Full-width pattern with idle gaps
    do_load(8'b1110_0101, 4'd8, 1'b1, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] b;
      b = 8'b1110_0101;
      bit_in(b[i]);
      idle($urandom_range(0, 3));
    end
    chk("gap_cnt", 32'(match_cnt), 1);

    // Illegal length suppresses detection until a legal load
    do_load(8'b0000_1011, 4'd0, 1'b1, 1'b1);
    chk("err_set", 32'(cfg_err), 1);
    for (int i = 0; i < 3; i++) stream(32'b1011, 4);
    chk("err_cnt", 32'(match_cnt), 0);
    do_load(8'b0000_1011, 4'd4, 1'b1, 1'b0);
    chk("err_clr", 32'(cfg_err), 0);
    stream(32'b1011, 4);
    chk("resume_cnt", 32'(match_cnt), 1);

    // Two-bit counter saturation and clear-with-match
    do_load(8'b0000_0011, 4'd2, 1'b1, 1'b1);
    stream(32'b111111, 6);
    chk("cnt2_sat", 32'(cnt2), 3);
    cnt_clr = 1'b1;
    bit_in(1'b1);
    chk("cnt2_clr_match", 32'(cnt2), 1);

    // Length-1 pattern, non-overlap still hits every matching bit
    do_load(8'b0000_0001, 4'd1, 1'b0, 1'b1);
    stream(32'b1101, 4);
    chk("len1_cnt", 32'(match_cnt), 3);

    // Reset mid-pattern discards history
    do_reset();
    stream(32'b101, 3);
    do_reset();
    stream(32'b1011, 4);
    stream(32'b1011, 4);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 199);
      x = 1'($urandom);
      x_valid = ($urandom_range(0, 3) != 0);
      if (r == 0) areset_n = 1'b0;
      if (r >= 1 && r <= 6) begin
        load = 1'b1;
        pat = 8'($urandom);
        pat_len = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(1, 4));
        overlap = 1'($urandom);
      end
      cnt_clr = (r >= 7 && r <= 9);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
